asymmetric_fifo_sync: RTL and testbench

//  Single-clock FIFO with independent write and read port widths, built on a simple-dual-port asymmetric RAM.

---
 rtl/asym_fifo_pkg.sv | 35 +++
 rtl/asym_sdp_ram.sv | 50 +++++
 rtl/asymmetric_fifo_sync.sv | 118 +++++++++++
 tb/tb_asymmetric_fifo_sync.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: width/depth derivations in
// minimum-width storage units.
package asym_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int minOf(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Storage is organised in units of the narrower port width.
    function automatic int calcMinW(input int widthW, input int widthR);
        return minOf(widthW, widthR);
    endfunction

    function automatic int calcUnits(input int width, input int widthW, input int widthR);
        return width / calcMinW(widthW, widthR);
    endfunction

    function automatic int calcDmin(input int depthW, input int widthW, input int widthR);
        return depthW * widthW / calcMinW(widthW, widthR);
    endfunction

endpackage

// File: rtl/asym_sdp_ram.sv
// Simple-dual-port RAM with a WIDTHW write port and WIDTHR read port over
// DMIN narrow units; registered read, no reset on the array.
module asym_sdp_ram
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHW = 8,
    parameter int WIDTHR = 32,
    parameter int DMIN   = 1024
) (
    input  logic                   clk,
    input  logic                   wrEn,
    input  logic [clog2(DMIN)-1:0] wrAddr,
    input  logic [WIDTHW-1:0]      wrData,
    input  logic                   rdEn,
    input  logic [clog2(DMIN)-1:0] rdAddr,
    output logic [WIDTHR-1:0]      rdData
);

    localparam int MINW = calcMinW(WIDTHW, WIDTHR);
    localparam int UW   = calcUnits(WIDTHW, WIDTHW, WIDTHR);
    localparam int UR   = calcUnits(WIDTHR, WIDTHW, WIDTHR);
    localparam int AW   = clog2(DMIN);

    logic [MINW-1:0] mem [DMIN];
    logic [AW-1:0]   wrLaneAddr [UW];
    logic [AW-1:0]   rdLaneAddr [UR];

    // Port addresses are aligned to their word size, so base + lane equals {addr, lane}.
    for (genvar g = 0; g < UW; g++) begin : gWrLane
        assign wrLaneAddr[g] = wrAddr + AW'(g);
    end

    for (genvar g = 0; g < UR; g++) begin : gRdLane
        assign rdLaneAddr[g] = rdAddr + AW'(g);
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < UW; i++) begin
                mem[wrLaneAddr[i]] <= wrData[i*MINW +: MINW];
            end
        end
        if (rdEn) begin
            for (int i = 0; i < UR; i++) begin
                rdData[i*MINW +: MINW] <= mem[rdLaneAddr[i]];
            end
        end
    end

endmodule

// File: rtl/asymmetric_fifo_sync.sv
// Single-clock FIFO with independent write/read widths: pointer and level
// bookkeeping in narrow units, flag registers and endian lane mapping.
module asymmetric_fifo_sync
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHW     = 8,
    parameter int WIDTHR     = 32,
    parameter int DEPTHW     = 256,
    parameter int BIG_ENDIAN = 0,
    parameter int AFULL_THR  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WIDTHW-1:0] din,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    input  logic              rd_en,
    output logic [WIDTHR-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              underflow,
    output logic [clog2(calcDmin(DEPTHW, WIDTHW, WIDTHR)):0] level
);

    localparam int MINW = calcMinW(WIDTHW, WIDTHR);
    localparam int UW   = calcUnits(WIDTHW, WIDTHW, WIDTHR);
    localparam int UR   = calcUnits(WIDTHR, WIDTHW, WIDTHR);
    localparam int DMIN = calcDmin(DEPTHW, WIDTHW, WIDTHR);
    localparam int AW   = clog2(DMIN);
    localparam int PW   = AW + 1;

    localparam logic [PW-1:0] UW_P   = PW'(UW);
    localparam logic [PW-1:0] UR_P   = PW'(UR);
    localparam logic [PW-1:0] DMIN_P = PW'(DMIN);
    // Free write words <= AFULL_THR is the same as free units < (AFULL_THR+1)*UW.
    localparam logic [31:0]   AFULL_LIM = 32'((AFULL_THR + 1) * UW);

    logic [PW-1:0]     wrPtr, rdPtr, wrPtrNext, rdPtrNext;
    logic [PW-1:0]     levelNext, freeNext;
    logic              wrAccept, rdAccept, doutLoaded;
    logic [WIDTHW-1:0] ramWrData;
    logic [WIDTHR-1:0] ramRdData, ramRdOrdered;

    always_comb begin
        wrAccept  = wr_en & ~full & ~clr;
        rdAccept  = rd_en & ~empty & ~clr;
        wrPtrNext = wrPtr;
        rdPtrNext = rdPtr;
        if (clr) begin
            wrPtrNext = '0;
            rdPtrNext = '0;
        end else begin
            if (wrAccept) wrPtrNext = wrPtr + UW_P;
            if (rdAccept) rdPtrNext = rdPtr + UR_P;
        end
        levelNext = wrPtrNext - rdPtrNext;
        freeNext  = DMIN_P - levelNext;
    end

    // Flags are computed from the post-edge level so they are registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            level       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            dout_valid  <= 1'b0;
            doutLoaded  <= 1'b0;
        end else begin
            wrPtr       <= wrPtrNext;
            rdPtr       <= rdPtrNext;
            level       <= levelNext;
            full        <= freeNext < UW_P;
            almost_full <= 32'(freeNext) < AFULL_LIM;
            empty       <= levelNext < UR_P;
            overflow    <= wr_en & full & ~clr;
            underflow   <= rd_en & empty & ~clr;
            dout_valid  <= rdAccept;
            doutLoaded  <= doutLoaded | rdAccept;
        end
    end

    // Big-endian mode reverses lane order on both sides of the RAM.
    for (genvar g = 0; g < UW; g++) begin : gWrOrder
        localparam int SRC = (BIG_ENDIAN != 0) ? (UW - 1 - g) : g;
        assign ramWrData[g*MINW +: MINW] = din[SRC*MINW +: MINW];
    end

    for (genvar g = 0; g < UR; g++) begin : gRdOrder
        localparam int SRC = (BIG_ENDIAN != 0) ? (UR - 1 - g) : g;
        assign ramRdOrdered[g*MINW +: MINW] = ramRdData[SRC*MINW +: MINW];
    end

    asym_sdp_ram #(
        .WIDTHW (WIDTHW),
        .WIDTHR (WIDTHR),
        .DMIN   (DMIN)
    ) uRam (
        .clk    (clk),
        .wrEn   (wrAccept),
        .wrAddr (wrPtr[AW-1:0]),
        .wrData (ramWrData),
        .rdEn   (rdAccept),
        .rdAddr (rdPtr[AW-1:0]),
        .rdData (ramRdData)
    );

    // The RAM array has no reset, so dout reads as zero until the first accepted read.
    assign dout = doutLoaded ? ramRdOrdered : '0;

endmodule

// File: tb/tb_asymmetric_fifo_sync.sv
// Scoreboard bench: two 8->32 FIFOs (little/big endian) share one stimulus pair,
// two 32->8 FIFOs share another; monitors pop expected read data on dout_valid.
module tb_asymmetric_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic pClr, pWr, pRd;
    logic [7:0] pDin;
    logic qClr, qWr, qRd;
    logic [31:0] qDin;

    logic aFull, aAfull, aOvf, aValid, aEmpty, aUdf;
    logic bFull, bAfull, bOvf, bValid, bEmpty, bUdf;
    logic cFull, cAfull, cOvf, cValid, cEmpty, cUdf;
    logic dFull, dAfull, dOvf, dValid, dEmpty, dUdf;
    logic [31:0] aDout, bDout;
    logic [7:0]  cDout, dDout;
    logic [4:0]  aLevel, bLevel, cLevel, dLevel;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] expA[$];
    logic [31:0] expB[$];
    logic [7:0]  expC[$];
    logic [7:0]  expD[$];

    asymmetric_fifo_sync #(.WIDTHW(8), .WIDTHR(32), .DEPTHW(16), .BIG_ENDIAN(0), .AFULL_THR(4)) uA (
        .clk(clk), .rstn(rstn), .clr(pClr), .wr_en(pWr), .din(pDin), .full(aFull),
        .almost_full(aAfull), .overflow(aOvf), .rd_en(pRd), .dout(aDout), .dout_valid(aValid),
        .empty(aEmpty), .underflow(aUdf), .level(aLevel));

    asymmetric_fifo_sync #(.WIDTHW(8), .WIDTHR(32), .DEPTHW(16), .BIG_ENDIAN(1), .AFULL_THR(4)) uB (
        .clk(clk), .rstn(rstn), .clr(pClr), .wr_en(pWr), .din(pDin), .full(bFull),
        .almost_full(bAfull), .overflow(bOvf), .rd_en(pRd), .dout(bDout), .dout_valid(bValid),
        .empty(bEmpty), .underflow(bUdf), .level(bLevel));

    asymmetric_fifo_sync #(.WIDTHW(32), .WIDTHR(8), .DEPTHW(4), .BIG_ENDIAN(0), .AFULL_THR(4)) uC (
        .clk(clk), .rstn(rstn), .clr(qClr), .wr_en(qWr), .din(qDin), .full(cFull),
        .almost_full(cAfull), .overflow(cOvf), .rd_en(qRd), .dout(cDout), .dout_valid(cValid),
        .empty(cEmpty), .underflow(cUdf), .level(cLevel));

    asymmetric_fifo_sync #(.WIDTHW(32), .WIDTHR(8), .DEPTHW(4), .BIG_ENDIAN(1), .AFULL_THR(4)) uD (
        .clk(clk), .rstn(rstn), .clr(qClr), .wr_en(qWr), .din(qDin), .full(dFull),
        .almost_full(dAfull), .overflow(dOvf), .rd_en(qRd), .dout(dDout), .dout_valid(dValid),
        .empty(dEmpty), .underflow(dUdf), .level(dLevel));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of stimulus on the selected pair, then returns inputs to idle.
    task automatic applyStimulus(input bit useQ, input logic wr, input logic [31:0] din,
                                 input logic rd, input logic clr);
        if (!useQ) begin
            pWr = wr; pDin = din[7:0]; pRd = rd; pClr = clr;
        end else begin
            qWr = wr; qDin = din; qRd = rd; qClr = clr;
        end
        @(posedge clk);
        #1;
        pWr = 1'b0; pRd = 1'b0; pClr = 1'b0;
        qWr = 1'b0; qRd = 1'b0; qClr = 1'b0;
    endtask

    task automatic checkPairP(input string name, input logic expEmpty, input logic expFull,
                              input logic [4:0] expLevel);
        checkOutput({name, " A empty"}, {31'b0, aEmpty}, {31'b0, expEmpty});
        checkOutput({name, " B empty"}, {31'b0, bEmpty}, {31'b0, expEmpty});
        checkOutput({name, " A full"}, {31'b0, aFull}, {31'b0, expFull});
        checkOutput({name, " A level"}, {27'b0, aLevel}, {27'b0, expLevel});
        checkOutput({name, " B level"}, {27'b0, bLevel}, {27'b0, expLevel});
    endtask

    task automatic expectP(input logic [31:0] a, input logic [31:0] b);
        expA.push_back(a);
        expB.push_back(b);
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && aValid === 1'b1) begin
            if (expA.size() == 0) checkOutput("A dout_valid with no pending read", {31'b0, aValid}, 32'h0);
            else checkOutput("A dout", aDout, expA.pop_front());
        end
        if (rstn === 1'b1 && bValid === 1'b1) begin
            if (expB.size() == 0) checkOutput("B dout_valid with no pending read", {31'b0, bValid}, 32'h0);
            else checkOutput("B dout", bDout, expB.pop_front());
        end
        if (rstn === 1'b1 && cValid === 1'b1) begin
            if (expC.size() == 0) checkOutput("C dout_valid with no pending read", {31'b0, cValid}, 32'h0);
            else checkOutput("C dout", {24'b0, cDout}, {24'b0, expC.pop_front()});
        end
        if (rstn === 1'b1 && dValid === 1'b1) begin
            if (expD.size() == 0) checkOutput("D dout_valid with no pending read", {31'b0, dValid}, 32'h0);
            else checkOutput("D dout", {24'b0, dDout}, {24'b0, expD.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  model[$];
        logic [7:0]  b0, b1, b2, b3, rdByte;
        logic [31:0] words [4];
        logic        rWr, rRd, rClr;
        bit          wAcc, rAcc;

        pClr = 0; pWr = 0; pRd = 0; pDin = '0;
        qClr = 0; qWr = 0; qRd = 0; qDin = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkPairP("reset", 1'b1, 1'b0, 5'd0);
        checkOutput("reset A dout", aDout, 32'h0);
        checkOutput("reset A dout_valid", {31'b0, aValid}, 32'h0);
        checkOutput("reset A almost_full", {31'b0, aAfull}, 32'h0);
        checkOutput("reset C empty", {31'b0, cEmpty}, 32'h1);
        checkOutput("reset D full", {31'b0, dFull}, 32'h0);
        rstn = 1'b1;

        // Packing 8->32: empty until four bytes are stored
        applyStimulus(0, 1, 32'h11, 0, 0);
        applyStimulus(0, 1, 32'h22, 0, 0);
        applyStimulus(0, 1, 32'h33, 0, 0);
        checkPairP("three bytes", 1'b1, 1'b0, 5'd3);
        applyStimulus(0, 1, 32'h44, 0, 0);
        checkPairP("four bytes", 1'b0, 1'b0, 5'd4);
        expectP(32'h44332211, 32'h11223344);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("pack A dout_valid", {31'b0, aValid}, 32'h1);
        checkOutput("pack B dout_valid", {31'b0, bValid}, 32'h1);
        checkPairP("after pack read", 1'b1, 1'b0, 5'd0);

        // Underflow: dout holds, no valid
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("underflow A pulse", {31'b0, aUdf}, 32'h1);
        checkOutput("underflow B pulse", {31'b0, bUdf}, 32'h1);
        checkOutput("underflow A dout_valid", {31'b0, aValid}, 32'h0);
        checkOutput("underflow A dout held", aDout, 32'h44332211);
        checkOutput("underflow B dout held", bDout, 32'h11223344);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("underflow A pulse end", {31'b0, aUdf}, 32'h0);

        // Fill 16 bytes, almost_full from level 12
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 32'(i + 1), 0, 0);
            if (i == 10) checkOutput("afull at level 11", {31'b0, aAfull}, 32'h0);
            if (i == 11) begin
                checkOutput("A afull at level 12", {31'b0, aAfull}, 32'h1);
                checkOutput("B afull at level 12", {31'b0, bAfull}, 32'h1);
            end
        end
        checkPairP("filled", 1'b0, 1'b1, 5'd16);

        // Write while full with a concurrent read: write dropped, read accepted
        expectP(32'h04030201, 32'h01020304);
        applyStimulus(0, 1, 32'hEE, 1, 0);
        checkOutput("overflow A pulse", {31'b0, aOvf}, 32'h1);
        checkOutput("overflow B pulse", {31'b0, bOvf}, 32'h1);
        checkOutput("overflow A level", {27'b0, aLevel}, 32'd12);
        checkOutput("overflow A full", {31'b0, aFull}, 32'h0);
        checkOutput("overflow A afull", {31'b0, aAfull}, 32'h1);
        checkOutput("overflow A dout_valid", {31'b0, aValid}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("overflow A pulse end", {31'b0, aOvf}, 32'h0);
        expectP(32'h08070605, 32'h05060708);
        expectP(32'h0C0B0A09, 32'h090A0B0C);
        expectP(32'h100F0E0D, 32'h0D0E0F10);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        checkPairP("drained", 1'b1, 1'b0, 5'd0);

        // Unpacking 32->8
        applyStimulus(1, 1, 32'hA1B2C3D4, 0, 0);
        checkOutput("unpack C level", {27'b0, cLevel}, 32'd4);
        checkOutput("unpack C empty", {31'b0, cEmpty}, 32'h0);
        expC.push_back(8'hD4); expC.push_back(8'hC3); expC.push_back(8'hB2); expC.push_back(8'hA1);
        expD.push_back(8'hA1); expD.push_back(8'hB2); expD.push_back(8'hC3); expD.push_back(8'hD4);
        repeat (4) applyStimulus(1, 0, 0, 1, 0);
        checkOutput("unpack C empty after", {31'b0, cEmpty}, 32'h1);
        checkOutput("unpack D level after", {27'b0, dLevel}, 32'd0);

        words[0] = 32'h11223344; words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC; words[3] = 32'hDDEEFF00;
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1, 1, words[w], 0, 0);
            if (w == 2) checkOutput("unpack C full at 3 words", {31'b0, cFull}, 32'h0);
        end
        checkOutput("unpack C full", {31'b0, cFull}, 32'h1);
        checkOutput("unpack D level full", {27'b0, dLevel}, 32'd16);
        applyStimulus(1, 1, 32'h12345678, 0, 0);
        checkOutput("unpack D overflow", {31'b0, dOvf}, 32'h1);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                expC.push_back(words[w][k*8 +: 8]);
                expD.push_back(words[w][(3-k)*8 +: 8]);
            end
        end
        repeat (16) applyStimulus(1, 0, 0, 1, 0);
        checkOutput("unpack D empty after drain", {31'b0, dEmpty}, 32'h1);

        // Random-rate traffic on the 8->32 pair with a flush mid-stream
        for (int cyc = 0; cyc < 100; cyc++) begin
            rWr  = ($urandom_range(0, 3) != 0);
            rRd  = ($urandom_range(0, 9) < ((cyc < 40) ? 1 : 4));
            rClr = (cyc == 60);
            rdByte = 8'($urandom);
            if (rClr) begin
                model.delete();
            end else begin
                rAcc = rRd && (model.size() >= 4);
                wAcc = rWr && (model.size() < 16);
                if (rAcc) begin
                    b0 = model.pop_front(); b1 = model.pop_front();
                    b2 = model.pop_front(); b3 = model.pop_front();
                    expectP({b3, b2, b1, b0}, {b0, b1, b2, b3});
                end
                if (wAcc) model.push_back(rdByte);
            end
            applyStimulus(0, rWr, {24'b0, rdByte}, rRd, rClr);
            checkOutput("random A level", {27'b0, aLevel}, 32'(model.size()));
            checkOutput("random B empty", {31'b0, bEmpty}, {31'b0, (model.size() < 4)});
            checkOutput("random A full", {31'b0, aFull}, {31'b0, (model.size() == 16)});
            if (rClr) checkOutput("clr A dout_valid", {31'b0, aValid}, 32'h0);
        end

        // Reset mid-traffic
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 32'h5A, 0, 0);
        applyStimulus(0, 1, 32'h6B, 0, 0);
        applyStimulus(0, 1, 32'h7C, 0, 0);
        applyStimulus(0, 1, 32'h8D, 0, 0);
        expectP(32'h8D7C6B5A, 32'h5A6B7C8D);
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 32'(8'hC0 + i), 0, 0);
        checkOutput("pre-reset A full", {31'b0, aFull}, 32'h1);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checkPairP("async reset", 1'b1, 1'b0, 5'd0);
        checkOutput("async reset A dout", aDout, 32'h0);
        checkOutput("async reset B dout", bDout, 32'h0);
        checkOutput("async reset A dout_valid", {31'b0, aValid}, 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        checkOutput("A pending reads", 32'(expA.size()), 32'd0);
        checkOutput("B pending reads", 32'(expB.size()), 32'd0);
        checkOutput("C pending reads", 32'(expC.size()), 32'd0);
        checkOutput("D pending reads", 32'(expD.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
